// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and FSM encoding for the register-file dump reader.
// Defaults match the core's register file instantiation.
package reg_dump_reader_pkg;

  localparam int unsigned NumRegsDef = 32;
  localparam int unsigned AddrWDef   = 5;
  localparam int unsigned DataWDef   = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register file read port over 0..NUM_REGS-1 and streams each word
// out on a valid/ready interface tagged with its index and a last flag.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned NUM_REGS = NumRegsDef,
  parameter int unsigned ADDR_W   = AddrWDef,
  parameter int unsigned DATA_W   = DataWDef
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic                last_q, last_d;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    index_d   = index_q;
    last_d    = last_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d   = StRead;
          rd_addr_d = '0;
        end
      end
      StRead: begin
        if (abort) begin
          state_d   = StIdle;
          valid_d   = 1'b0;
          rd_addr_d = '0;
        end else begin
          data_d  = rd_data;
          index_d = rd_addr_q;
          last_d  = (rd_addr_q == LastAddr);
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        // Abort wins over a same-cycle handshake; that word is dropped.
        if (abort) begin
          state_d   = StIdle;
          valid_d   = 1'b0;
          rd_addr_d = '0;
        end else if (out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = StDone;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = StRead;
          end
        end
      end
      StDone: begin
        state_d   = StIdle;
        rd_addr_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      index_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      index_q   <= index_d;
      last_q    <= last_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign busy      = (state_q == StRead) || (state_q == StHold);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a behavioural register file plus a
// queue of expected words, checked by an independent negedge monitor.
module tb_reg_dump_reader;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clkin = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [N];
  logic [DW-1:0] seen_data [N];

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int words_seen = 0;
  int ready_mode = 0;
  int bp_left = 0;

  always #5 clkin = ~clkin;

  // Register file read port: combinational, register 0 hardwired to zero.
  assign rd_data = (rd_addr == '0) ? '0 : regs[rd_addr];

  reg_dump_reader #(
    .NUM_REGS(N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clkin);
    cyc++;
  end

  // Downstream ready: 0 always high, 1 random, 2 stall index 7 for bp_left edges.
  initial forever begin
    @(posedge clkin);
    #1;
    case (ready_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (out_valid && out_index == AW'(7) && bp_left > 0) begin
          out_ready = 1'b0;
          bp_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: compare every presented word with the head of the model queue.
  initial forever begin
    @(negedge clkin);
    if (reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected word", 64'(out_index), 64'hFFFF);
        end else begin
          check("word index", 64'(out_index), 64'(exp_q[0].idx));
          check("word data", 64'(out_data), 64'(exp_q[0].data));
          check("word last", 64'(out_last), 64'(exp_q[0].last));
          if (out_ready && !abort) begin
            seen_data[out_index] = out_data;
            void'(exp_q.pop_front());
            words_seen++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("queue empty at done", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic start_dump(input bit push);
    if (push) begin
      for (int i = 0; i < int'(N); i++) begin
        exp_t e;
        e.idx  = AW'(i);
        e.data = (i == 0) ? '0 : regs[i];
        e.last = (i == int'(N) - 1);
        exp_q.push_back(e);
      end
      exp_done++;
    end
    @(posedge clkin);
    #1 start = 1'b1;
    @(posedge clkin);
    #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  // A write is visible only to registers the engine has not yet read.
  task automatic reg_write(input int r, input logic [DW-1:0] v);
    logic [AW-1:0] held;
    held = (exp_q.size() > 0) ? exp_q[0].idx : '0;
    regs[r] = v;
    foreach (exp_q[j]) begin
      if (int'(exp_q[j].idx) == r && AW'(r) > held) exp_q[j].data = v;
    end
  endtask

  task automatic wait_idle(input int limit, input string name, input bit rand_wr);
    int k;
    for (k = 0; k < limit; k++) begin
      @(posedge clkin);
      #2;
      if (rand_wr && out_valid && exp_q.size() > 0 && $urandom_range(0, 3) == 0)
        reg_write(int'($urandom_range(1, N - 1)), $urandom);
      if (!busy && !done && exp_q.size() == 0) break;
    end
    if (k == limit) check({name, " timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_index(input int idx, input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      @(posedge clkin);
      #1;
      if (out_valid && out_index == AW'(idx)) break;
    end
    if (k == 500) check({name, " index timeout"}, 64'd0, 64'd1);
  endtask

  task automatic preload();
    for (int i = 0; i < int'(N); i++) regs[i] = DW'(4 * i);
  endtask

  initial begin
    int w0;
    preload();
    ready_mode = 0;
    repeat (3) @(posedge clkin);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_index", 64'(out_index), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset rd_addr", 64'(rd_addr), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clkin);

    // Full dump, ready tied high: latency and count.
    w0 = words_seen;
    start_dump(1'b1);
    check("valid low at start edge", 64'(out_valid), 64'd0);
    check("busy after start", 64'(busy), 64'd1);
    @(posedge clkin);
    #1 check("first valid latency", 64'(out_valid), 64'd1);
    wait_idle(300, "full dump", 1'b0);
    check("full dump words", 64'(words_seen - w0), 64'(N));
    check("full dump done count", 64'(done_cnt), 64'(exp_done));
    check("done cycle", 64'(done_cyc - start_cyc), 64'(2 * N));
    check("idx5 data", 64'(seen_data[5]), 64'h14);
    check("idx31 data", 64'(seen_data[31]), 64'h7C);
    check("rd_addr after done", 64'(rd_addr), 64'd0);

    // Backpressure on index 7.
    w0 = words_seen;
    bp_left = 3;
    ready_mode = 2;
    start_dump(1'b1);
    wait_idle(300, "backpressure", 1'b0);
    check("bp words", 64'(words_seen - w0), 64'(N));
    check("bp done count", 64'(done_cnt), 64'(exp_done));
    check("bp stall used", 64'(bp_left), 64'd0);
    ready_mode = 0;

    // Abort in HOLD on index 10, then restart from 0.
    start_dump(1'b1);
    wait_index(10, "abort");
    abort = 1'b1;
    @(posedge clkin);
    #1 abort = 1'b0;
    exp_q.delete();
    exp_done--;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    repeat (4) @(posedge clkin);
    #1 check("abort no done", 64'(done_cnt), 64'(exp_done));
    start_dump(1'b1);
    wait_idle(300, "restart", 1'b0);
    check("restart done count", 64'(done_cnt), 64'(exp_done));

    // Start while busy is ignored.
    w0 = words_seen;
    start_dump(1'b1);
    wait_index(3, "busy start");
    start = 1'b1;
    @(posedge clkin);
    #1 start = 1'b0;
    wait_idle(300, "busy start", 1'b0);
    repeat (4) @(posedge clkin);
    #1;
    check("busy start words", 64'(words_seen - w0), 64'(N));
    check("busy start done count", 64'(done_cnt), 64'(exp_done));
    check("busy start idle", 64'(busy), 64'd0);

    // Writes while holding index 12.
    start_dump(1'b1);
    for (int k = 0; k < 500; k++) begin
      @(posedge clkin);
      #2;
      if (out_valid && exp_q.size() > 0 && exp_q[0].idx == AW'(12)) break;
    end
    reg_write(20, 32'hDEADBEEF);
    reg_write(4, 32'h12345678);
    wait_idle(300, "write", 1'b0);
    check("write reg20 visible", 64'(seen_data[20]), 64'hDEADBEEF);
    check("write reg4 not visible", 64'(seen_data[4]), 64'h10);
    preload();

    // Asynchronous reset during index 15.
    start_dump(1'b1);
    wait_index(15, "reset");
    #2 reset = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst out_data", 64'(out_data), 64'd0);
    check("async rst out_index", 64'(out_index), 64'd0);
    check("async rst out_last", 64'(out_last), 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst rd_addr", 64'(rd_addr), 64'd0);
    exp_q.delete();
    exp_done--;
    @(posedge clkin);
    #3 reset = 1'b1;
    repeat (6) @(posedge clkin);
    #1;
    check("post rst idle busy", 64'(busy), 64'd0);
    check("post rst idle valid", 64'(out_valid), 64'd0);
    check("post rst no done", 64'(done_cnt), 64'(exp_done));

    // Randomised dumps with random backpressure and random writes.
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(N); i++) regs[i] = $urandom;
      w0 = words_seen;
      start_dump(1'b1);
      wait_idle(2000, "random", 1'b1);
      check("random words", 64'(words_seen - w0), 64'(N));
      check("random done count", 64'(done_cnt), 64'(exp_done));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
